mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between an instruction-fetch port and a
// data port. The data port has fixed priority. The winner's request is
// latched for the whole access. An access that sees no memory acknowledge
// within TIMEOUT cycles completes with zero data and sets a sticky error flag.

module mem_port_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_ack_o,
   output logic [31:0] if_data_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_ack_o,
   output logic [31:0] dm_rdata_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic        stall_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_DM = 2'd1,
      GNT_IF = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Counter value seen in the last permitted grant cycle.
   localparam logic [7:0] CNT_LAST_C = 8'(TIMEOUT - 1);

   state_t      state_r;
   state_t      state_s;
   logic        grant_dm_s;
   logic        grant_if_s;
   logic        mem_done_s;
   logic        timeout_s;

   logic [7:0]  cnt_r;
   logic        mem_en_r;
   logic        mem_we_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;
   logic        if_ack_r;
   logic        dm_ack_r;
   logic [31:0] if_data_r;
   logic [31:0] dm_rdata_r;
   logic        err_r;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and per-cycle event decode.
   always_comb begin
      state_s    = state_r;
      grant_dm_s = 1'b0;
      grant_if_s = 1'b0;
      mem_done_s = 1'b0;
      timeout_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_i && dm_req_i) begin
               state_s    = GNT_DM;
               grant_dm_s = 1'b1;
            end else if (start_i && if_req_i) begin
               state_s    = GNT_IF;
               grant_if_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         GNT_DM, GNT_IF: begin
            if (mem_ack_i) begin
               state_s    = RESP;
               mem_done_s = 1'b1;
            end else if (cnt_r == CNT_LAST_C) begin
               state_s   = RESP;
               timeout_s = 1'b1;
            end else begin
               state_s = state_r;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Request latching, wait counter, response capture and sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r       <= 8'd0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
         if_ack_r    <= 1'b0;
         dm_ack_r    <= 1'b0;
         if_data_r   <= 32'h0000_0000;
         dm_rdata_r  <= 32'h0000_0000;
         err_r       <= 1'b0;
      end else begin
         // Acks are single-cycle pulses unless re-armed below.
         if_ack_r <= 1'b0;
         dm_ack_r <= 1'b0;
         if (grant_dm_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= dm_we_i;
            mem_addr_r  <= dm_addr_i;
            mem_wdata_r <= dm_wdata_i;
            cnt_r       <= 8'd0;
         end else if (grant_if_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr_i;
            mem_wdata_r <= 32'h0000_0000;
            cnt_r       <= 8'd0;
         end else if (mem_done_s || timeout_s) begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            if (state_r == GNT_DM) begin
               dm_ack_r   <= 1'b1;
               dm_rdata_r <= mem_done_s ? mem_rdata_i : 32'h0000_0000;
            end else begin
               if_ack_r  <= 1'b1;
               if_data_r <= mem_done_s ? mem_rdata_i : 32'h0000_0000;
            end
            if (timeout_s) begin
               err_r <= 1'b1;
            end else begin
               err_r <= err_r;
            end
         end else if (mem_en_r) begin
            cnt_r <= cnt_r + 8'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign if_ack_o    = if_ack_r;
   assign if_data_o   = if_data_r;
   assign dm_ack_o    = dm_ack_r;
   assign dm_rdata_o  = dm_rdata_r;
   assign mem_en_o    = mem_en_r;
   assign mem_we_o    = mem_we_r;
   assign mem_addr_o  = mem_addr_r;
   assign mem_wdata_o = mem_wdata_r;
   assign err_o       = err_r;

   // A requester stalls until the cycle its acknowledge is presented.
   assign stall_o = (if_req_i & ~if_ack_r) | (dm_req_i & ~dm_ack_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory responder model,
// an ack scoreboard, and one task per scenario.

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_i, start_i;
   logic        if_req_i, if_ack_o;
   logic [31:0] if_addr_i, if_data_o;
   logic        dm_req_i, dm_we_i, dm_ack_o;
   logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
   logic        mem_en_o, mem_we_o, mem_ack_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        stall_o, err_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_dm_q[$];
   int mem_delay = 0;
   bit mem_dead  = 1'b0;
   int en_cnt    = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .stall_o(stall_o), .err_o(err_o)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h0050_0093;
      else return a ^ 32'h5A5A_0000;
   endfunction

   // Memory model: acks mem_delay cycles after mem_en_o rises (never if mem_dead).
   always @(negedge clk) begin
      if (mem_en_o === 1'b1) begin
         if (!mem_dead && en_cnt == mem_delay) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_word(mem_addr_o);
         end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_BAD0;
         end
         en_cnt = en_cnt + 1;
      end else begin
         mem_ack_i   = 1'b0;
         mem_rdata_i = 32'hBAD0_BAD0;
         en_cnt      = 0;
      end
   end

   // Scoreboard: each ack pops the oldest expected word of its port.
   always @(negedge clk) begin
      if (if_ack_o === 1'b1 && dm_ack_o === 1'b1) begin
         checks++; errors++;
         $display("FAIL both_acks got if_ack=1 dm_ack=1 want at most one");
      end
      if (if_ack_o === 1'b1) begin
         checks++;
         if (exp_if_q.size() == 0) begin
            errors++;
            $display("FAIL if_ack_unexpected got ack data=%h want no ack", if_data_o);
         end else begin
            logic [31:0] e;
            e = exp_if_q.pop_front();
            if (if_data_o !== e) begin
               errors++;
               $display("FAIL if_data got %h want %h", if_data_o, e);
            end
         end
      end
      if (dm_ack_o === 1'b1) begin
         checks++;
         if (exp_dm_q.size() == 0) begin
            errors++;
            $display("FAIL dm_ack_unexpected got ack data=%h want no ack", dm_rdata_o);
         end else begin
            logic [31:0] e;
            e = exp_dm_q.pop_front();
            if (dm_rdata_o !== e) begin
               errors++;
               $display("FAIL dm_rdata got %h want %h", dm_rdata_o, e);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0;
      if_req_i = 1'b0; if_addr_i = 32'h0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
      step(); step();
      checks++;
      if (mem_en_o !== 1'b0 || mem_we_o !== 1'b0) begin
         errors++; $display("FAIL reset_mem_ctl got en=%b we=%b want 0 0", mem_en_o, mem_we_o);
      end
      checks++;
      if (if_ack_o !== 1'b0 || dm_ack_o !== 1'b0 || err_o !== 1'b0) begin
         errors++; $display("FAIL reset_flags got if_ack=%b dm_ack=%b err=%b want 0 0 0", if_ack_o, dm_ack_o, err_o);
      end
      checks++;
      if (if_data_o !== 32'h0 || dm_rdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
         errors++; $display("FAIL reset_regs got %h %h %h %h want all 0", if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o);
      end
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_stall got %b want 0", stall_o);
      end
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_if_only();
      int acks = 0; int lat = 0; bit we_seen = 1'b0; bit addr_bad = 1'b0; bit en_at_ack = 1'b0;
      mem_delay = 2; start_i = 1'b1;
      if_addr_i = 32'h0000_0010; if_req_i = 1'b1;
      exp_if_q.push_back(32'h0050_0093);
      for (int cyc = 0; cyc < 40 && acks == 0; cyc++) begin
         step();
         if (mem_en_o === 1'b1) begin
            if (mem_we_o !== 1'b0) we_seen = 1'b1;
            if (mem_addr_o !== 32'h0000_0010) addr_bad = 1'b1;
         end
         if (if_ack_o === 1'b1) begin
            acks++; lat = cyc + 1; en_at_ack = mem_en_o; if_req_i = 1'b0;
         end
      end
      checks++;
      if (acks != 1) begin errors++; $display("FAIL if_only_ack got %0d acks want 1", acks); end
      checks++;
      if (lat != mem_delay + 2) begin errors++; $display("FAIL if_only_latency got %0d want %0d", lat, mem_delay + 2); end
      checks++;
      if (we_seen || addr_bad || en_at_ack) begin
         errors++; $display("FAIL if_only_mem got we_seen=%b addr_bad=%b en_at_ack=%b want 0 0 0", we_seen, addr_bad, en_at_ack);
      end
      step(); step(); step();
      checks++;
      if (if_data_o !== 32'h0050_0093 || exp_if_q.size() != 0) begin
         errors++; $display("FAIL if_data_hold got %h pending=%0d want 00500093 0", if_data_o, exp_if_q.size());
      end
   endtask

   task automatic test_conflict();
      bit first_seen = 1'b0; bit dm_done = 1'b0; bit if_done = 1'b0;
      bit stall_bad = 1'b0; bit we_bad = 1'b0;
      mem_delay = 1;
      if_addr_i = 32'h0000_0040; if_req_i = 1'b1;
      dm_addr_i = 32'h0000_0020; dm_wdata_i = 32'hDEAD_BEEF; dm_we_i = 1'b1; dm_req_i = 1'b1;
      exp_dm_q.push_back(mem_word(32'h0000_0020));
      exp_if_q.push_back(mem_word(32'h0000_0040));
      for (int cyc = 0; cyc < 60 && !if_done; cyc++) begin
         step();
         if (mem_en_o === 1'b1 && !first_seen) begin
            first_seen = 1'b1;
            checks++;
            if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_0020 || mem_wdata_o !== 32'hDEAD_BEEF) begin
               errors++; $display("FAIL conflict_dm_first got we=%b addr=%h wdata=%h want 1 00000020 deadbeef", mem_we_o, mem_addr_o, mem_wdata_o);
            end
         end
         if (mem_en_o === 1'b1 && dm_done && mem_we_o !== 1'b0) we_bad = 1'b1;
         if (!if_done && if_ack_o !== 1'b1 && stall_o !== 1'b1) stall_bad = 1'b1;
         if (dm_ack_o === 1'b1) begin
            dm_done = 1'b1; dm_req_i = 1'b0; dm_we_i = 1'b0;
         end
         if (if_ack_o === 1'b1) begin
            checks++;
            if (!dm_done || stall_o !== 1'b0) begin
               errors++; $display("FAIL conflict_if_ack got dm_done=%b stall=%b want 1 0", dm_done, stall_o);
            end
            if_done = 1'b1; if_req_i = 1'b0;
         end
      end
      checks++;
      if (!if_done || stall_bad || we_bad) begin
         errors++; $display("FAIL conflict_seq got if_done=%b stall_bad=%b we_bad=%b want 1 0 0", if_done, stall_bad, we_bad);
      end
      step();
   endtask

   task automatic test_timeout();
      int gnt = 0; bit done = 1'b0; bit err_early = 1'b0; logic err_ack = 1'b0;
      mem_dead = 1'b1;
      dm_addr_i = 32'h0000_0080; dm_we_i = 1'b0; dm_req_i = 1'b1;
      exp_dm_q.push_back(32'h0000_0000);
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         step();
         if (mem_en_o === 1'b1) begin
            gnt++;
            if (err_o !== 1'b0) err_early = 1'b1;
         end
         if (dm_ack_o === 1'b1) begin
            done = 1'b1; err_ack = err_o; dm_req_i = 1'b0;
         end
      end
      checks++;
      if (!done || gnt != 16) begin errors++; $display("FAIL timeout_cycles got done=%b gnt=%0d want 1 16", done, gnt); end
      checks++;
      if (err_early || err_ack !== 1'b1) begin errors++; $display("FAIL timeout_err got early=%b at_ack=%b want 0 1", err_early, err_ack); end
      mem_dead = 1'b0; mem_delay = 0; done = 1'b0;
      if_addr_i = 32'h0000_0010; if_req_i = 1'b1;
      exp_if_q.push_back(32'h0050_0093);
      for (int cyc = 0; cyc < 30 && !done; cyc++) begin
         step();
         if (if_ack_o === 1'b1) begin done = 1'b1; if_req_i = 1'b0; end
      end
      step();
      checks++;
      if (!done || err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got done=%b err=%b want 1 1", done, err_o); end
   endtask

   task automatic test_reset_mid();
      bit en_seen = 1'b0; bit done = 1'b0;
      mem_dead = 1'b1;
      if_addr_i = 32'h0000_0010; if_req_i = 1'b1;
      for (int cyc = 0; cyc < 10 && !en_seen; cyc++) begin
         step();
         if (mem_en_o === 1'b1) en_seen = 1'b1;
      end
      step(); step();
      rst_i = 1'b1;
      step();
      checks++;
      if (!en_seen || mem_en_o !== 1'b0 || if_ack_o !== 1'b0 || err_o !== 1'b0 || mem_addr_o !== 32'h0) begin
         errors++; $display("FAIL reset_mid got en_seen=%b en=%b ack=%b err=%b addr=%h want 1 0 0 0 0", en_seen, mem_en_o, if_ack_o, err_o, mem_addr_o);
      end
      rst_i = 1'b0; mem_dead = 1'b0; mem_delay = 1;
      exp_if_q.push_back(32'h0050_0093);
      for (int cyc = 0; cyc < 30 && !done; cyc++) begin
         step();
         if (if_ack_o === 1'b1) begin done = 1'b1; if_req_i = 1'b0; end
      end
      checks++;
      if (!done) begin errors++; $display("FAIL reset_reserve got no ack want ack"); end
      step();
   endtask

   task automatic test_start_gate();
      bit bad = 1'b0; bit done = 1'b0;
      start_i = 1'b0;
      if_addr_i = 32'h0000_0044; if_req_i = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         step();
         if (mem_en_o !== 1'b0 || stall_o !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL start_block got en=%b stall=%b want 0 1", mem_en_o, stall_o); end
      mem_delay = 3;
      exp_if_q.push_back(mem_word(32'h0000_0044));
      start_i = 1'b1;
      step();
      checks++;
      if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h0000_0044) begin
         errors++; $display("FAIL start_grant got en=%b addr=%h want 1 00000044", mem_en_o, mem_addr_o);
      end
      start_i = 1'b0;
      for (int cyc = 0; cyc < 30 && !done; cyc++) begin
         step();
         if (if_ack_o === 1'b1) begin done = 1'b1; if_req_i = 1'b0; end
      end
      checks++;
      if (!done) begin errors++; $display("FAIL start_no_abort got no ack want ack"); end
      start_i = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] gaddr[3];
      int ng = 0; int dm_acks = 0; bit if_done = 1'b0; bit hold_bad = 1'b0;
      logic prev_en = 1'b0; logic [31:0] prev_addr = 32'h0;
      mem_delay = 1;
      dm_addr_i = 32'h0000_0100; dm_we_i = 1'b0; dm_req_i = 1'b1;
      if_addr_i = 32'h0000_0300; if_req_i = 1'b1;
      exp_dm_q.push_back(mem_word(32'h0000_0100));
      exp_if_q.push_back(mem_word(32'h0000_0300));
      for (int cyc = 0; cyc < 60 && !if_done; cyc++) begin
         step();
         if (mem_en_o === 1'b1 && prev_en !== 1'b1) begin
            if (ng < 3) gaddr[ng] = mem_addr_o;
            ng++;
            if (ng == 1) begin
               dm_addr_i = 32'h0000_0200;
               exp_dm_q.push_back(mem_word(32'h0000_0200));
            end
         end
         if (mem_en_o === 1'b1 && prev_en === 1'b1 && mem_addr_o !== prev_addr) hold_bad = 1'b1;
         prev_en = mem_en_o; prev_addr = mem_addr_o;
         if (dm_ack_o === 1'b1) begin
            dm_acks++;
            if (dm_acks == 2) dm_req_i = 1'b0;
         end
         if (if_ack_o === 1'b1) begin if_done = 1'b1; if_req_i = 1'b0; end
      end
      checks++;
      if (ng != 3 || dm_acks != 2 || hold_bad) begin
         errors++; $display("FAIL b2b_count got grants=%0d dm_acks=%0d hold_bad=%b want 3 2 0", ng, dm_acks, hold_bad);
      end else begin
         checks++;
         if (gaddr[0] !== 32'h0000_0100 || gaddr[1] !== 32'h0000_0200 || gaddr[2] !== 32'h0000_0300) begin
            errors++; $display("FAIL b2b_order got %h %h %h want 00000100 00000200 00000300", gaddr[0], gaddr[1], gaddr[2]);
         end
      end
      step(); step();
      checks++;
      if (exp_if_q.size() != 0 || exp_dm_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got if=%0d dm=%0d pending want 0 0", exp_if_q.size(), exp_dm_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i = 1'b1; start_i = 1'b0;
      if_req_i = 1'b0; if_addr_i = 32'h0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      test_reset();
      test_if_only();
      test_conflict();
      test_timeout();
      test_reset_mid();
      test_start_gate();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
